spi_slave: RTL
==============

SPI_SLAVE -- requirements
Module: spi_slave

Interface
REQ-001 Parameter SYNC_STAGES, default 2, number of synchronizer flops on spi_sclk, spi_mosi and spi_cs (minimum 2).
REQ-002 clk  input  1  system clock; all logic on its rising edge.
REQ-003 reset  input  1  reset, asynchronous and active-high.
REQ-004 spi_sclk  input  1  SPI clock from the external master (mode 0: CPOL=0, CPHA=0).
REQ-005 spi_mosi  input  1  serial data from the master, MSB first.
REQ-006 spi_cs  input  1  chip select, active-low.
REQ-007 spi_miso  output  1  serial data to the master, MSB first.
REQ-008 spi_miso_oe  output  1  MISO output enable, high only while spi_cs is low.
REQ-009 tx_data  input  8  next byte to return to the master.
REQ-010 tx_valid  input  1  tx_data is valid.
REQ-011 tx_ready  output  1  the one-entry TX holding register is empty.
REQ-012 rx_data  output  8  last fully received byte, held until the next byte completes.
REQ-013 rx_valid  output  1  one-cycle pulse when rx_data is updated; no backpressure.
REQ-014 underrun  output  1  one-cycle pulse when a byte load finds the holding register empty.

Function
REQ-015 spi_sclk, spi_mosi and spi_cs SHALL pass through SYNC_STAGES flops; edges SHALL be detected on the synchronized signals only.
REQ-016 Supported spi_sclk frequency SHALL be at most clk/8.
REQ-017 Handshake: a byte SHALL be accepted on a cycle with tx_valid && tx_ready; tx_ready SHALL drop the following cycle.
REQ-018 FSM states are IDLE and SHIFT; reset enters IDLE.
REQ-019 IDLE -> SHIFT on a synchronized cs falling edge: bit counter = 0, TX shift register loaded (REQ-023), spi_miso_oe = 1.
REQ-020 In SHIFT, each synchronized sclk rising edge SHALL shift spi_mosi into the RX shift register LSB and increment the 3-bit bit counter.
REQ-021 In SHIFT, each synchronized sclk falling edge SHALL shift the TX register left by one; spi_miso = TX register bit 7 at all times.
REQ-022 On the 8th rising edge (counter wraps 7 -> 0): rx_data <= assembled byte and rx_valid pulses the next cycle; an unread previous byte is overwritten.
REQ-023 Byte load (at cs fall, and at the falling edge after the 8th rising edge) SHALL take the holding register and mark it empty; if empty, load 8'h00 and pulse underrun.
REQ-024 A tx accept in the same cycle as a byte load SHALL fill the holding register; it is not used by that load.
REQ-025 SHIFT -> IDLE on a synchronized cs rising edge: partial RX bits discarded, no rx_valid, counter = 0, spi_miso_oe = 0; holding register untouched.
REQ-026 Edges of sclk while in IDLE SHALL be ignored.

Reset
REQ-027 While reset: state IDLE, counter 0, shift registers 0, holding empty, tx_ready 1, rx_data 8'h00, rx_valid 0, underrun 0, spi_miso 0, spi_miso_oe 0, synchronizers to idle levels (sclk 0, cs 1).
REQ-028 Reset mid-transfer SHALL abort immediately with no rx_valid.

Structure
REQ-029 FSM state encoding and the SPI mode constant SHALL live in the shared spi package used by the existing SPI master.
REQ-030 The synchronizer SHALL be a sub-module spi_sync (parameterized depth, one bit), instantiated three times.

Verification
REQ-031 Preload tx 8'hA5, master sends 8'h3C -> master reads 8'hA5, rx_data = 8'h3C with one rx_valid pulse.
REQ-032 Empty holding, master sends 8'hFF -> MISO shifts 8'h00, one underrun pulse, rx_data = 8'hFF.
REQ-033 Preload 8'h11, push 8'h22 during byte 1, two-byte burst under one cs -> master reads 8'h11 then 8'h22, two rx_valid pulses.
REQ-034 cs deasserted after 5 sclk -> no rx_valid, spi_miso_oe = 0, next full transfer receives correctly.
REQ-035 Assert reset after 3 bits -> all outputs at REQ-027 values within one clk, no rx_valid.
REQ-036 tx_valid asserted in the cs-fall load cycle with holding empty -> underrun pulses, new byte sent in the following byte.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared SPI definitions used by both the SPI master and the SPI slave.
package spi_pkg;

  localparam logic       SPI_CPOL = 1'b0;
  localparam logic       SPI_CPHA = 1'b0;
  localparam logic [1:0] SPI_MODE = {SPI_CPOL, SPI_CPHA};

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  typedef logic [7:0] spi_byte_t;

endpackage

// File: rtl/spi_sync.sv
// Single-bit multi-flop synchronizer with a configurable reset (idle) level.
module spi_sync #(
  parameter int   STAGES    = 2,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d_i,
  output logic q_o
);

  logic [STAGES-1:0] sync_q;

  // NOTE: the flops reset to the bus idle level so no false edge appears when reset is released.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sync_q <= {STAGES{RESET_VAL}};
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
    end
  end

  assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/spi_slave.sv
// SPI mode-0 slave: oversampled by clk, one-entry TX holding register, byte-wide RX.
module spi_slave
  import spi_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       spi_sclk,
  input  logic       spi_mosi,
  input  logic       spi_cs,
  output logic       spi_miso,
  output logic       spi_miso_oe,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       underrun
);

  logic sclk_s, mosi_s, cs_s;

  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .reset(reset), .d_i(spi_sclk), .q_o(sclk_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b0)) u_sync_mosi (
    .clk(clk), .reset(reset), .d_i(spi_mosi), .q_o(mosi_s));
  spi_sync #(.STAGES(SYNC_STAGES), .RESET_VAL(1'b1)) u_sync_cs (
    .clk(clk), .reset(reset), .d_i(spi_cs), .q_o(cs_s));

  logic       sclk_prev_q, cs_prev_q;
  logic [0:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  spi_byte_t  rx_shift_q, rx_shift_d;
  spi_byte_t  tx_shift_q, tx_shift_d;
  spi_byte_t  hold_q, hold_d;
  logic       hold_full_q, hold_full_d;
  spi_byte_t  rx_data_q, rx_data_d;
  logic       rx_valid_q, rx_valid_d;
  logic       underrun_q, underrun_d;
  logic       oe_q, oe_d;
  logic       load_pend_q, load_pend_d;
  logic       byte_load;

  wire sclk_rise = sclk_s & ~sclk_prev_q;
  wire sclk_fall = ~sclk_s & sclk_prev_q;
  wire cs_fall   = ~cs_s & cs_prev_q;
  wire cs_rise   = cs_s & ~cs_prev_q;
  wire tx_accept = tx_valid & ~hold_full_q;

  always_comb begin
    // NOTE: every next-state value defaults to hold, so no path can infer a latch.
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    rx_shift_d  = rx_shift_q;
    tx_shift_d  = tx_shift_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    rx_data_d   = rx_data_q;
    rx_valid_d  = 1'b0;
    underrun_d  = 1'b0;
    oe_d        = oe_q;
    load_pend_d = load_pend_q;
    byte_load   = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (cs_fall) begin
          state_d     = ST_SHIFT;
          bit_cnt_d   = 3'd0;
          oe_d        = 1'b1;
          load_pend_d = 1'b0;
          byte_load   = 1'b1;
        end
      end
      ST_SHIFT: begin
        if (cs_rise) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = 3'd0;
          rx_shift_d  = '0;
          oe_d        = 1'b0;
          load_pend_d = 1'b0;
        end else if (sclk_rise) begin
          rx_shift_d = {rx_shift_q[6:0], mosi_s};
          bit_cnt_d  = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
            rx_data_d   = {rx_shift_q[6:0], mosi_s};
            rx_valid_d  = 1'b1;
            load_pend_d = 1'b1;
          end
        end else if (sclk_fall) begin
          // The falling edge that closes a byte presents the next byte instead of shifting.
          if (load_pend_q) begin
            byte_load   = 1'b1;
            load_pend_d = 1'b0;
          end else begin
            tx_shift_d = {tx_shift_q[6:0], 1'b0};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (byte_load) begin
      if (hold_full_q) begin
        tx_shift_d  = hold_q;
        hold_full_d = 1'b0;
      end else begin
        tx_shift_d = '0;
        underrun_d = 1'b1;
      end
    end

    // An accept can only happen while the holding register is empty, so it never races a load.
    if (tx_accept) begin
      hold_d      = tx_data;
      hold_full_d = 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sclk_prev_q <= 1'b0;
      cs_prev_q   <= 1'b1;
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      rx_shift_q  <= '0;
      tx_shift_q  <= '0;
      hold_q      <= '0;
      hold_full_q <= 1'b0;
      rx_data_q   <= '0;
      rx_valid_q  <= 1'b0;
      underrun_q  <= 1'b0;
      oe_q        <= 1'b0;
      load_pend_q <= 1'b0;
    end else begin
      sclk_prev_q <= sclk_s;
      cs_prev_q   <= cs_s;
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      rx_shift_q  <= rx_shift_d;
      tx_shift_q  <= tx_shift_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      rx_data_q   <= rx_data_d;
      rx_valid_q  <= rx_valid_d;
      underrun_q  <= underrun_d;
      oe_q        <= oe_d;
      load_pend_q <= load_pend_d;
    end
  end

  assign spi_miso    = tx_shift_q[7];
  assign spi_miso_oe = oe_q;
  assign tx_ready    = ~hold_full_q;
  assign rx_data     = rx_data_q;
  assign rx_valid    = rx_valid_q;
  assign underrun    = underrun_q;

endmodule
